// File: rtl/flipper_axi_pkg.sv
// Shared AXI read-channel encodings, payload width and FSM state type.
package flipper_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [2:0] AXI_SIZE_16B    = 3'b100;

    // R-channel payload is {rdata[127:0], rresp[1:0], rlast}
    localparam int R_PAYLOAD_W = 131;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } rd_state_t;

    // Only 16-byte FIXED or INCR bursts ever touch the RAM
    function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
        return (burst != AXI_BURST_WRAP) && (burst != AXI_BURST_RSVD) && (size == AXI_SIZE_16B);
    endfunction

endpackage

// File: rtl/axi_r_skid_buf.sv
// Two-entry output buffer with bypass: an arriving beat is presented on the
// same cycle when empty and parked if the consumer is not ready.
module axi_r_skid_buf
    import flipper_axi_pkg::*;
#(
    parameter int W = R_PAYLOAD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_mem [2];
    logic         r_head;
    logic [1:0]   r_count;

    logic w_push;
    logic w_store;
    logic w_deq;
    logic w_tail;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0) || i_valid;
    assign o_data  = (r_count != 2'd0) ? r_mem[r_head] : i_data;

    assign w_push  = i_valid && o_ready;
    assign w_store = w_push && !((r_count == 2'd0) && i_ready);
    assign w_deq   = (r_count != 2'd0) && i_ready;
    assign w_tail  = r_head ^ r_count[0];

    // Store parked beats and advance the read pointer; reset flushes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_mem[w_tail] <= i_data;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

endmodule

// File: rtl/efb_axi_read_slave.sv
// AXI read slave in front of a synchronous 128-bit RAM: one burst at a time,
// one beat per cycle, SLVERR for unsupported bursts and out-of-range words.
module efb_axi_read_slave
    import flipper_axi_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           araddr_s,
    input  logic [1:0]            arburst_s,
    input  logic [3:0]            arlen_s,
    input  logic [2:0]            arsize_s,
    input  logic                  arvalid_s,
    output logic                  arready_s,
    output logic [127:0]          rdata_s,
    output logic [1:0]            rresp_s,
    output logic                  rlast_s,
    output logic                  rvalid_s,
    input  logic                  rready_s,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [127:0]          mem_rdata
);

    rd_state_t r_state;
    rd_state_t w_next_state;

    logic [28:0]           r_idx;
    logic [3:0]            r_remain;
    logic                  r_fixed;
    logic                  r_burst_err;
    logic [1:0]            r_occ;
    logic                  r_pend_valid;
    logic                  r_pend_err;
    logic                  r_pend_last;
    logic [DEPTH_LOG2-1:0] r_mem_addr;

    logic                   w_ar_fire;
    logic [27:0]            w_start_idx;
    logic                   w_in_range;
    logic                   w_beat_err;
    logic                   w_issue;
    logic                   w_pop;
    logic                   w_pop_last;
    logic                   w_buf_in_ready;
    logic                   w_buf_out_valid;
    logic [R_PAYLOAD_W-1:0] w_buf_in_data;
    logic [R_PAYLOAD_W-1:0] w_buf_out_data;
    logic                   w_unused;

    // Byte offset within a 16-byte word never selects anything
    assign w_unused    = &{1'b0, araddr_s[3:0]};
    assign w_start_idx = araddr_s[31:4] - BASE_ADDR[31:4];

    assign arready_s  = (r_state == ST_IDLE) && !reset;
    assign w_ar_fire  = arvalid_s && arready_s;
    assign w_in_range = (r_idx[28:DEPTH_LOG2] == '0);
    assign w_beat_err = r_burst_err || !w_in_range;

    // r_occ counts beats issued but not yet accepted, including the RAM read in flight
    assign w_issue   = (r_state == ST_BURST) && (r_occ != 2'd2) && w_buf_in_ready;
    assign mem_rd_en = w_issue && !w_beat_err;
    assign mem_addr  = mem_rd_en ? r_idx[DEPTH_LOG2-1:0] : r_mem_addr;

    assign w_buf_in_data = r_pend_valid ?
        {(r_pend_err ? 128'd0 : mem_rdata),
         (r_pend_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY),
         r_pend_last} : '0;

    assign {rdata_s, rresp_s, rlast_s} = w_buf_out_data;
    assign rvalid_s   = w_buf_out_valid;
    assign w_pop      = rvalid_s && rready_s;
    assign w_pop_last = w_pop && rlast_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave BURST once the final beat is issued, leave DRAIN on the rlast handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_fire) w_next_state = ST_BURST;
            ST_BURST: if (w_issue && (r_remain == 4'd0)) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_pop_last) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Burst context: capture on AR handshake, step per issued beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_remain    <= '0;
            r_fixed     <= 1'b0;
            r_burst_err <= 1'b0;
        end else if (w_ar_fire) begin
            r_idx       <= {1'b0, w_start_idx};
            r_remain    <= arlen_s;
            r_fixed     <= (arburst_s == AXI_BURST_FIXED);
            r_burst_err <= !burst_supported(arburst_s, arsize_s);
        end else if (w_issue) begin
            r_remain <= r_remain - 4'd1;
            if (!r_fixed) begin
                r_idx <= r_idx + 29'd1;
            end
        end
    end

    // Beat descriptor aligned with RAM latency, occupancy count and last RAM address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_err   <= 1'b0;
            r_pend_last  <= 1'b0;
            r_occ        <= 2'd0;
            r_mem_addr   <= '0;
        end else begin
            r_pend_valid <= w_issue;
            r_pend_err   <= w_beat_err;
            r_pend_last  <= (r_remain == 4'd0);
            r_occ        <= r_occ + {1'b0, w_issue} - {1'b0, w_pop};
            if (mem_rd_en) begin
                r_mem_addr <= r_idx[DEPTH_LOG2-1:0];
            end
        end
    end

    axi_r_skid_buf #(
        .W(R_PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_pend_valid),
        .o_ready (w_buf_in_ready),
        .i_data  (w_buf_in_data),
        .o_valid (w_buf_out_valid),
        .i_ready (rready_s),
        .o_data  (w_buf_out_data)
    );

endmodule

// File: tb/tb_efb_axi_read_slave.sv
// Bench for efb_axi_read_slave: directed and random bursts against a
// queue-based model of the expected beats; RAM word n holds value n.
module tb_efb_axi_read_slave;

    localparam int          DEPTH_LOG2 = 6;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] BASE       = 32'h0001_0000;

    logic                  clk;
    logic                  reset;
    logic [31:0]           araddr_s;
    logic [1:0]            arburst_s;
    logic [3:0]            arlen_s;
    logic [2:0]            arsize_s;
    logic                  arvalid_s;
    logic                  arready_s;
    logic [127:0]          rdata_s;
    logic [1:0]            rresp_s;
    logic                  rlast_s;
    logic                  rvalid_s;
    logic                  rready_s;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [127:0]          mem_rdata;

    int nChecks = 0;
    int nFails  = 0;

    efb_axi_read_slave #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .araddr_s  (araddr_s),
        .arburst_s (arburst_s),
        .arlen_s   (arlen_s),
        .arsize_s  (arsize_s),
        .arvalid_s (arvalid_s),
        .arready_s (arready_s),
        .rdata_s   (rdata_s),
        .rresp_s   (rresp_s),
        .rlast_s   (rlast_s),
        .rvalid_s  (rvalid_s),
        .rready_s  (rready_s),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: word n reads as n one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= 128'(mem_addr);
        end else begin
            mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [130:0] observed, input logic [130:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Run one burst; abortAfter>0 stops right after that many beats have been accepted
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] burst, input logic [3:0] len,
                                 input logic [2:0] size, input int mode, input int abortAfter);
        logic [130:0]          expQ[$];
        logic [130:0]          expBeat;
        logic [130:0]          held;
        logic [31:0]           startIdx;
        logic [63:0]           idx;
        logic [DEPTH_LOG2-1:0] prevAddr;
        logic                  lastBit;
        logic                  stalled;
        bit                    bad;
        int                    expReads;
        int                    reads;
        int                    cyc;
        int                    firstValid;
        int                    popped;
        int                    budget;

        // Reference: list every beat the burst must return
        startIdx = (addr - BASE) >> 4;
        bad      = !((burst == 2'b00) || (burst == 2'b01)) || (size != 3'b100);
        expReads = 0;
        for (int i = 0; i <= int'(len); i++) begin
            idx     = 64'(startIdx) + ((burst == 2'b01) ? 64'(i) : 64'd0);
            lastBit = (i == int'(len));
            if (bad || (idx >= 64'(DEPTH))) begin
                expQ.push_back({128'd0, 2'b10, lastBit});
            end else begin
                expQ.push_back({64'd0, idx, 2'b00, lastBit});
                expReads++;
            end
        end

        araddr_s  = addr;
        arburst_s = burst;
        arlen_s   = len;
        arsize_s  = size;
        arvalid_s = 1'b1;
        budget    = 0;
        while (!arready_s && (budget < 50)) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!arready_s) begin
            checkOutput("ar_timeout", 131'(arready_s), 131'd1);
            arvalid_s = 1'b0;
            return;
        end
        prevAddr = mem_addr;
        @(posedge clk);
        #1;
        arvalid_s  = 1'b0;
        cyc        = 1;
        firstValid = 0;
        popped     = 0;
        reads      = 0;
        stalled    = 1'b0;
        held       = '0;

        while ((popped < int'(len) + 1) && (cyc < 300)) begin
            case (mode)
                0:       rready_s = 1'b1;
                1:       rready_s = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: rready_s = ($urandom_range(0, 9) < 7);
            endcase
            @(negedge clk);
            if (mem_rd_en) begin
                reads++;
            end else begin
                checkOutput("addr_hold", 131'(mem_addr), 131'(prevAddr));
            end
            prevAddr = mem_addr;
            if (rvalid_s && (firstValid == 0)) begin
                firstValid = cyc;
            end
            if (stalled) begin
                checkOutput("stall_valid", 131'(rvalid_s), 131'd1);
                checkOutput("stall_payload", {rdata_s, rresp_s, rlast_s}, held);
            end
            if (rvalid_s && rready_s) begin
                expBeat = expQ.pop_front();
                checkOutput($sformatf("beat%0d", popped), {rdata_s, rresp_s, rlast_s}, expBeat);
                popped++;
                stalled = 1'b0;
            end else begin
                stalled = rvalid_s;
                held    = {rdata_s, rresp_s, rlast_s};
            end
            if ((abortAfter != 0) && (popped == abortAfter)) begin
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rready_s = 1'b0;

        checkOutput("beat_count", 131'(popped), 131'(int'(len) + 1));
        checkOutput("first_rvalid", 131'(firstValid), 131'd2);
        checkOutput("read_count", 131'(reads), 131'(expReads));
        checkOutput("idle_return", 131'(arready_s), 131'd1);
    endtask

    // All reset-forced outputs must read zero
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_arready"}, 131'(arready_s), 131'd0);
        checkOutput({tag, "_rvalid"}, 131'(rvalid_s), 131'd0);
        checkOutput({tag, "_rpayload"}, {rdata_s, rresp_s, rlast_s}, 131'd0);
        checkOutput({tag, "_mem"}, 131'({mem_rd_en, mem_addr}), 131'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          sel;

        reset     = 1'b0;
        araddr_s  = '0;
        arburst_s = '0;
        arlen_s   = '0;
        arsize_s  = '0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;

        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("reset0");
        arvalid_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset1");
        arvalid_s = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_arready", 131'(arready_s), 131'd1);

        $display("[TB] directed bursts");
        applyStimulus(BASE + 32'h20, 2'b01, 4'd3, 3'b100, 0, 0);
        applyStimulus(BASE + 32'h20, 2'b01, 4'd3, 3'b100, 1, 0);
        applyStimulus(BASE + 32'h70, 2'b00, 4'd2, 3'b100, 0, 0);
        applyStimulus(BASE + 32'h3F0, 2'b01, 4'd1, 3'b100, 0, 0);
        applyStimulus(BASE + 32'h40, 2'b01, 4'd0, 3'b011, 0, 0);
        applyStimulus(BASE + 32'h10, 2'b10, 4'd2, 3'b100, 2, 0);
        applyStimulus(BASE + 32'h3C5, 2'b01, 4'd7, 3'b100, 1, 0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(BASE, 2'b01, 4'd7, 3'b100, 0, 2);
        reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        rready_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_rvalid_after", 131'(rvalid_s), 131'd0);
        applyStimulus(BASE + 32'h100, 2'b01, 4'd3, 3'b100, 0, 0);

        $display("[TB] random bursts");
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                addr = BASE - 32'(16 * $urandom_range(1, 4));
            end else begin
                addr = BASE + 32'(16 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 15));
            end
            sel = $urandom_range(0, 7);
            if (sel < 3) begin
                burst = 2'b00;
            end else if (sel < 6) begin
                burst = 2'b01;
            end else begin
                burst = 2'(sel - 4);
            end
            size = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
            applyStimulus(addr, burst, 4'($urandom_range(0, 15)), size, 2, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/efb_axi_read_slave.md
EFB_AXI_READ_SLAVE -- requirements
Module: efb_axi_read_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in 128-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0, aligned to 16*2^DEPTH_LOG2.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- araddr_s  in  32  burst start byte address
- arburst_s  in  2  burst type
- arlen_s  in  4  beats minus one
- arsize_s  in  3  beat size code
- arvalid_s  in  1  address valid
- arready_s  out  1  address ready
- rdata_s  out  128  read data
- rresp_s  out  2  beat response
- rlast_s  out  1  final beat
- rvalid_s  out  1  data valid
- rready_s  in  1  data ready
- mem_addr  out  DEPTH_LOG2  word address to synchronous RAM
- mem_rd_en  out  1  RAM read strobe
- mem_rdata  in  128  RAM data, valid exactly 1 cycle after mem_rd_en

Function
REQ-005 SHALL process one burst at a time; states IDLE, BURST, DRAIN.
REQ-006 SHALL drive arready_s=1 only in IDLE; capture araddr/arburst/arlen/arsize on arvalid_s&arready_s, then enter BURST.
REQ-007 SHALL compute word index = (araddr_s-BASE_ADDR)>>4; araddr_s[3:0] ignored.
REQ-008 SHALL issue mem_rd_en at T+1 for AR handshake at T; first rvalid_s at T+2.
REQ-009 SHALL sustain one beat per cycle while rready_s=1, using a 2-entry output buffer so no RAM read data is lost under backpressure.
REQ-010 SHALL issue mem_rd_en only when the buffer has a free slot, counting the in-flight read.
REQ-011 SHALL hold rdata_s/rresp_s/rlast_s stable while rvalid_s=1 and rready_s=0.
REQ-012 SHALL return arlen_s+1 beats, assert rlast_s on the final beat only.
REQ-013 SHALL step the word address +1 per beat for INCR (2'b01), hold it for FIXED (2'b00).
REQ-014 SHALL answer every beat with SLVERR (2'b10) and rdata_s=0 when arburst_s is WRAP or reserved, or arsize_s != 3'b100; no RAM reads.
REQ-015 SHALL answer an individual beat with SLVERR and rdata_s=0 when its word index is >= 2^DEPTH_LOG2 (start or INCR overrun); in-range beats are OKAY (2'b00).
REQ-016 SHALL enter DRAIN after the last RAM read is issued, return to IDLE the cycle after the rlast beat handshake; arready_s=1 in that cycle.
REQ-017 SHALL hold mem_addr stable when mem_rd_en=0.

Reset
REQ-018 SHALL, while reset=1, force arready_s=0, rvalid_s=0, rlast_s=0, rresp_s=0, rdata_s=0, mem_rd_en=0, mem_addr=0, state IDLE.
REQ-019 SHALL, on reset mid-burst, abandon the burst and flush the buffer immediately; the next burst after release starts clean.

Structure
REQ-020 SHALL take burst encodings, response encodings and size constant 3'b100 from shared package flipper_axi_pkg.
REQ-021 SHALL place the 2-entry output buffer in sub-module axi_r_skid_buf (128+2+1 bit payload, valid/ready both sides).

Verification
REQ-022 INCR, araddr=BASE+0x20, arlen=3, rready=1, RAM word n=n -> 4 OKAY beats data 2,3,4,5, rlast on 4th, first rvalid 2 cycles after AR.
REQ-023 Same burst, rready toggled 1,0,0,1,... -> same 4 beats in order, none duplicated or lost, outputs stable while stalled.
REQ-024 FIXED, arlen=2, word 7 -> three OKAY beats data 7.
REQ-025 INCR starting at last word, arlen=1 -> beat 1 OKAY, beat 2 SLVERR data 0, rlast on beat 2.
REQ-026 arsize=3'b011, arlen=0 -> one SLVERR beat, rlast=1, mem_rd_en never asserted.
REQ-027 reset pulsed after 2nd beat of arlen=7 burst -> rvalid low during reset; new burst afterwards returns correct data from beat 1.
